// File: rtl/rand_cell_picker.sv
// rtl/rand_cell_picker.sv - picks a random free board cell and a spawn tile value
//
// Optional feature macro: RAND_CELL_PICKER_FASTFULL_EN
//   When defined, a request against a completely full board completes on the
//   accepting edge without entering the scan.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   rand_in    in   16-bit random word, sampled when a request is accepted
//   occupied   in   CELLS-bit occupancy map, sampled when a request is accepted
//   req        in   spawn request, accepted only while idle
//   busy       out  scan in progress
//   done       out  one-cycle completion pulse
//   found      out  1 = free cell chosen, 0 = board full
//   cell_idx   out  chosen cell index
//   tile_four  out  1 = spawn a 4, 0 = spawn a 2
module rand_cell_picker #(
    parameter int         IDX_W       = 4,
    parameter logic [7:0] FOUR_THRESH = 8'd26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           rand_in,
    input  logic [2**IDX_W-1:0]   occupied,
    input  logic                  req,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [IDX_W-1:0]      cell_idx,
    output logic                  tile_four
);

    localparam int CELLS = 2**IDX_W;
    localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               four_q, four_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               found_q, found_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tile_q, tile_d;
    logic               fast_full;

    // Only the index bits and the top byte of the random word matter; the rest
    // is folded here so it is consumed explicitly.
    logic unused_rand;
    assign unused_rand = ^rand_in;

`ifdef RAND_CELL_PICKER_FASTFULL_EN
    assign fast_full = &occupied;
`else
    assign fast_full = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        four_d  = four_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        found_d = found_q;
        idx_d   = idx_q;
        tile_d  = tile_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (fast_full) begin
                        done_d  = 1'b1;
                        found_d = 1'b0;
                        idx_d   = '0;
                        tile_d  = 1'b0;
                    end else begin
                        snap_d  = occupied;
                        ptr_d   = rand_in[IDX_W-1:0];
                        cnt_d   = '0;
                        four_d  = (rand_in[15:8] < FOUR_THRESH);
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!snap_q[ptr_q]) begin
                    found_d = 1'b1;
                    idx_d   = ptr_q;
                    tile_d  = four_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (&cnt_q) begin
                    // Every cell visited once: the board is full.
                    found_d = 1'b0;
                    idx_d   = '0;
                    tile_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Natural IDX_W-bit overflow gives the wrap from the last cell to 0.
                    ptr_d = ptr_q + ONE;
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            four_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            idx_q   <= '0;
            tile_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            four_q  <= four_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            idx_q   <= idx_d;
            tile_q  <= tile_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign cell_idx  = idx_q;
    assign tile_four = tile_q;

endmodule

// File: tb/tb_rand_cell_picker.sv
// tb/tb_rand_cell_picker.sv - scoreboard bench for rand_cell_picker
module tb_rand_cell_picker;

`ifdef RAND_CELL_PICKER_FASTFULL_EN
    localparam bit FASTFULL = 1'b1;
`else
    localparam bit FASTFULL = 1'b0;
`endif
    localparam int NBUSY = 32768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rand_in = '0;
    logic [15:0] occupied = '0;
    logic        req = 1'b0;
    logic        busy, done, found, tile_four;
    logic [3:0]  cell_idx;

    rand_cell_picker #(.IDX_W(4), .FOUR_THRESH(8'd26)) dut (
        .clk(clk), .rst(rst), .rand_in(rand_in), .occupied(occupied), .req(req),
        .busy(busy), .done(done), .found(found), .cell_idx(cell_idx), .tile_four(tile_four)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit f;
        int idx;
        bit four;
        int due;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_busy [0:NBUSY-1];
    int   edge_n = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   started = 1'b0;
    bit   held_f = 1'b0;
    int   held_idx = 0;
    bit   held_four = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Reference: walk the board from the random start cell with modular arithmetic.
    task automatic model(input logic [15:0] occ, input logic [15:0] rnd,
                         output bit f, output int idx, output bit four, output int lat);
        int start;
        start = int'(rnd[3:0]);
        f = 1'b0; idx = 0; four = 1'b0; lat = FASTFULL ? 1 : 16;
        if (occ != 16'hFFFF) begin
            for (int k = 0; k < 16; k++) begin
                if (!occ[(start + k) % 16]) begin
                    f    = 1'b1;
                    idx  = (start + k) % 16;
                    four = (int'(rnd[15:8]) < 26);
                    lat  = k + 1;
                    break;
                end
            end
        end
    endtask

    // Called at a negedge; the next rising edge is the accepting edge E0.
    task automatic issue(input logic [15:0] occ, input logic [15:0] rnd, output int due);
        exp_t e;
        int   e0, lat;
        occupied = occ;
        rand_in  = rnd;
        req      = 1'b1;
        e0 = edge_n + 1;
        model(occ, rnd, e.f, e.idx, e.four, lat);
        e.due = e0 + lat;
        due = e.due;
        exp_q.push_back(e);
        if (!(FASTFULL && occ == 16'hFFFF))
            for (int t = e0; t < e.due; t++) exp_busy[t] = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("busy", busy, exp_busy[edge_n]);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", done, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_edge", edge_n, e.due);
                    chk("found", found, e.f);
                    chk("cell_idx", cell_idx, e.idx);
                    chk("tile_four", tile_four, e.four);
                    held_f = e.f; held_idx = e.idx; held_four = e.four;
                end
            end else begin
                chk("hold_found", found, held_f);
                chk("hold_idx", cell_idx, held_idx);
                chk("hold_four", tile_four, held_four);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int due, e0, p, gap, mode;
        logic [15:0] occ;

        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_idx", cell_idx, 4'd0);
        chk("rst_four", tile_four, 1'b0);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);

        // Empty board, then wrap-around, then full board.
        issue(16'h0000, 16'h00A5, due); wait_until(due + 1);
        issue(16'hC000, 16'h800E, due); wait_until(due + 2);
        issue(16'hFFFF, 16'h1234, due); wait_until(due + 1);

        // Snapshot: occupancy change and extra req mid-scan are ignored; a req
        // on the completing edge is ignored and held into the done cycle for a
        // back-to-back accept.
        issue(16'h00FF, 16'h0000, due);
        e0 = due - 9;
        wait_until(e0 + 2);
        occupied = 16'h0000; req = 1'b1;
        @(negedge clk); req = 1'b0;
        wait_until(due - 1);
        occupied = 16'h0000; rand_in = 16'h0007; req = 1'b1;
        wait_until(due);
        issue(16'h0F0F, 16'hFF02, due); wait_until(due + 1);

        // Reset mid-scan.
        issue(16'h7FFF, 16'h0000, due);
        e0 = due - 16;
        wait_until(e0 + 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_found", found, 1'b0);
        chk("mid_rst_idx", cell_idx, 4'd0);
        chk("mid_rst_four", tile_four, 1'b0);
        exp_q.delete();
        for (int t = edge_n; t < edge_n + 40; t++) exp_busy[t] = 1'b0;
        held_f = 1'b0; held_idx = 0; held_four = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue(16'h0000, 16'h0003, due); wait_until(due + 3);

        // Randomized traffic with back-to-back, gaps and ignored requests.
        for (int n = 0; n < 200; n++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: occ = 16'($urandom);
                1: occ = 16'($urandom | $urandom);
                2: occ = 16'($urandom | $urandom | $urandom);
                default: occ = ($urandom_range(0, 1) == 0) ? 16'hFFFF
                                                         : ~(16'h0001 << $urandom_range(0, 15));
            endcase
            issue(occ, 16'($urandom), due);
            if (due >= edge_n + 2 && $urandom_range(0, 1) == 1) begin
                p = edge_n + 1 + $urandom_range(0, due - edge_n - 1);
                wait_until(p - 1);
                occupied = 16'($urandom); rand_in = 16'($urandom); req = 1'b1;
                @(negedge clk); req = 1'b0;
            end
            gap = $urandom_range(0, 3);
            wait_until(due + gap);
        end

        wait_until(edge_n + 20);
        chk("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rand_cell_picker.md
Name: rand_cell_picker

Overview:
- Consumes the 16-bit pseudo-random word from the LFSR stage and picks a random free cell on the game board for spawning a new tile.
- Also decides the spawned tile value: 2, or 4 with low probability.
- The board controller issues a one-cycle request. The block snapshots the board occupancy and the random word, then scans linearly from a random start cell, one cell per clock, with wrap-around.
- It returns the chosen cell index, or reports that the board is full.

Parameters:
- IDX_W, 4, cell index width; cell count CELLS = 2**IDX_W (localparam; default 16 cells, 4x4 board).
- FOUR_THRESH, 8'd26, tile is 4 when rand_in[15:8] < FOUR_THRESH (default ≈10%).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rand_in  in  16  random word from the LFSR stage; sampled only when a request is accepted.
- occupied  in  CELLS  bit i = 1 means cell i is holding a tile; sampled only when a request is accepted.
- req  in  1  spawn request; accepted only when busy=0.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; result is valid.
- found  out  1  1 = free cell chosen, 0 = board full.
- cell_idx  out  IDX_W  chosen cell index.
- tile_four  out  1  1 = spawn 4, 0 = spawn 2.

Behaviour:
- Reset (async, any state, including mid-scan):
  - State returns to IDLE.
  - busy, done, found, cell_idx, tile_four, the snapshot, the pointer and the counter all clear to 0.
  - An in-flight scan is discarded; no done pulse is issued.
- States: IDLE, SCAN. All outputs are registered.
- IDLE, on an edge with req=1:
  - snap <= occupied.
  - ptr <= rand_in[IDX_W-1:0].
  - cnt <= 0.
  - four_r <= (rand_in[15:8] < FOUR_THRESH).
  - busy <= 1; go to SCAN.
- SCAN, each edge:
  - If snap[ptr]==0: found<=1, cell_idx<=ptr, tile_four<=four_r, done<=1, busy<=0, go to IDLE.
  - Else if cnt==CELLS-1: found<=0, cell_idx<=0, tile_four<=0, done<=1, busy<=0, go to IDLE.
  - Else: ptr<=ptr+1, wrapping CELLS-1 to 0 by natural IDX_W-bit overflow; cnt<=cnt+1.
- cnt width is IDX_W bits.
- Latency: let E0 be the edge that accepts req and k the number of occupied cells skipped from the start cell.
  - done is high for the cycle following edge E0+min(k+1, CELLS).
  - Best case: 1 edge. Full board: CELLS edges.
- done is high for exactly one cycle; it clears on the next edge.
- found, cell_idx and tile_four hold their values until the next completion or reset.
- req while busy=1 is ignored; it is not queued.
- req on the same edge that done is set: the block is not yet in IDLE at that edge, so req is ignored.
- req in the cycle where done=1: the block is in IDLE, so req is accepted; the new scan starts while done drops.
- Changes to occupied or rand_in during SCAN have no effect (snapshot semantics).

Optional Feature:
- Macro: RAND_CELL_PICKER_FASTFULL_EN.
- With the macro defined:
  - In IDLE, if req=1 and &occupied==1, the block does not enter SCAN.
  - On that same edge E0: done<=1, found<=0, cell_idx<=0, tile_four<=0, busy stays 0.
  - Result: done is high in the cycle after E0.
- Without the macro: a full board takes the normal CELLS-edge scan path.

Test Plan:
- Empty board:
  - Stimulus: occupied=16'h0000, rand_in=16'h00A5, req pulse.
  - Response: done 1 edge after E0; found=1, cell_idx=5, tile_four=1 (0x00<26); busy high for 1 cycle.
- Wrap-around:
  - Stimulus: occupied=16'hC000, rand_in=16'h800E, req.
  - Response: cells 14 and 15 are skipped; done 3 edges after E0; found=1, cell_idx=0, tile_four=0 (0x80≥26).
- Full board, macro off:
  - Stimulus: occupied=16'hFFFF, rand_in=16'h1234, req.
  - Response: busy for 16 cycles; done 16 edges after E0; found=0, cell_idx=0.
  - With RAND_CELL_PICKER_FASTFULL_EN: done 1 edge after E0, busy never asserts.
- Snapshot and ignore:
  - Stimulus: occupied=16'h00FF, rand_in=16'h0000, req. During the scan, set occupied=16'h0000 and pulse req again.
  - Response: done 9 edges after E0, cell_idx=8; exactly one done pulse; the second req has no effect.
- Reset mid-scan:
  - Stimulus: occupied=16'h7FFF, rand_in=16'h0000, req; assert rst at cycle 4.
  - Response: all outputs are 0 immediately; no done pulse follows.
  - After rst is released, req with occupied=16'h0000, rand_in=16'h0003 gives cell_idx=3 after 1 edge.
- Back-to-back:
  - Stimulus: issue the next req in the cycle where done=1.
  - Response: it is accepted; the second result follows with correct latency and the first result's outputs are retained until then.
